// File: rtl/spell_mem_pkg.sv
// Shared types and constants for the SPELL two-region memory.
// The optional wait-state feature is enabled by SPELL_MEM_WAIT_EN.
package spell_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CODE_DEPTH  = 32;
    localparam int DEF_DATA_DEPTH  = 8;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WAIT_CYCLES = 3;

    localparam logic REGION_CODE = 1'b0;
    localparam logic REGION_DATA = 1'b1;

    function automatic int max_depth(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spell_mem_bank.sv
// Single-port word array with combinational read, write enable and a
// clear port used by the post-reset zeroing sequence.
module spell_mem_bank #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              write_en,
    input  logic              clear_en,
    input  logic [ADDR_W-1:0] clear_idx,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] read_data,
    output logic              in_range
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_W + 1;
    // One extra bit so a depth of exactly 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_V = AW1'(DEPTH);

    logic [DATA_W-1:0] mem [0:(2**IDX_W)-1];
    logic              clear_hit;

    assign in_range  = ({1'b0, addr} < DEPTH_V);
    assign clear_hit = clear_en && ({1'b0, clear_idx} < DEPTH_V);

    always_ff @(posedge clock) begin
        if (clear_hit)
            mem[clear_idx[IDX_W-1:0]] <= '0;
        else if (write_en && in_range)
            mem[addr[IDX_W-1:0]] <= data_in;
    end

    assign read_data = in_range ? mem[addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/spell_mem_regions.sv
// Two-region (code/data) memory with post-reset clear and select/ready handshake.
// Define SPELL_MEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module spell_mem_regions
    import spell_mem_pkg::*;
#(
    parameter int CODE_DEPTH  = DEF_CODE_DEPTH,
    parameter int DATA_DEPTH  = DEF_DATA_DEPTH,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              select,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              memory_type_data,
    input  logic              write,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ready,
    output logic              addr_error,
    output logic              busy
);

    localparam int CLEAR_COUNT = max_depth(CODE_DEPTH, DATA_DEPTH);
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(CLEAR_COUNT - 1);

`ifdef SPELL_MEM_WAIT_EN
    localparam bit WAIT_ON = (WAIT_CYCLES != 0);
    logic [3:0] wait_cnt;
`else
    // WAIT_CYCLES has no effect without the wait-state build option.
    localparam bit WAIT_ON = 1'b0 && (WAIT_CYCLES != 0);
`endif

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clear_idx;
    logic              access;
    logic              clear_en;
    logic              code_we;
    logic              data_we;
    logic              code_in_range;
    logic              data_in_range;
    logic              sel_in_range;
    logic [DATA_W-1:0] code_rdata;
    logic [DATA_W-1:0] data_rdata;
    logic [DATA_W-1:0] sel_rdata;

    always_ff @(posedge clock) begin
        if (reset)
            state <= CLEAR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        access     = 1'b0;
        case (state)
            CLEAR: if (clear_idx == CLEAR_LAST) next_state = IDLE;
            IDLE: begin
                if (select) begin
                    next_state = WAIT_ON ? WAIT : DONE;
                    access     = !WAIT_ON;
                end
            end
            WAIT: begin
`ifdef SPELL_MEM_WAIT_EN
                if (!select)
                    next_state = IDLE;
                else if (wait_cnt == 4'd1) begin
                    next_state = DONE;
                    access     = 1'b1;
                end
`else
                next_state = IDLE;
`endif
            end
            DONE: if (!select) next_state = IDLE;
            default: next_state = CLEAR;
        endcase
        // A write racing a reset is dropped.
        if (reset) access = 1'b0;
    end

    always_comb begin
        busy         = (state == CLEAR);
        data_ready   = (state == DONE);
        clear_en     = (state == CLEAR);
        code_we      = access && write && (memory_type_data == REGION_CODE);
        data_we      = access && write && (memory_type_data == REGION_DATA);
        sel_in_range = (memory_type_data == REGION_DATA) ? data_in_range : code_in_range;
        sel_rdata    = (memory_type_data == REGION_DATA) ? data_rdata : code_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset)
            clear_idx <= '0;
        else if (state == CLEAR)
            clear_idx <= clear_idx + ADDR_W'(1);
    end

`ifdef SPELL_MEM_WAIT_EN
    always_ff @(posedge clock) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == IDLE && select)
            wait_cnt <= 4'(WAIT_CYCLES);
        else if (state == WAIT)
            wait_cnt <= wait_cnt - 4'd1;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            addr_error <= 1'b0;
        end else if (access) begin
            addr_error <= !sel_in_range;
            if (!write)
                data_out <= sel_rdata;
        end else if (state == DONE && !select) begin
            addr_error <= 1'b0;
        end
    end

    spell_mem_bank #(
        .DEPTH (CODE_DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) code_bank (
        .clock    (clock),
        .write_en (code_we),
        .clear_en (clear_en),
        .clear_idx(clear_idx),
        .addr     (addr),
        .data_in  (data_in),
        .read_data(code_rdata),
        .in_range (code_in_range)
    );

    spell_mem_bank #(
        .DEPTH (DATA_DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) data_bank (
        .clock    (clock),
        .write_en (data_we),
        .clear_en (clear_en),
        .clear_idx(clear_idx),
        .addr     (addr),
        .data_in  (data_in),
        .read_data(data_rdata),
        .in_range (data_in_range)
    );

endmodule

// File: tb/tb_spell_mem_regions.sv
// Directed scoreboard bench for spell_mem_regions (default depths/widths).
module tb_spell_mem_regions;
    import spell_mem_pkg::*;

    localparam int CD = 32;
    localparam int DD = 8;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int WC = 3;
`ifdef SPELL_MEM_WAIT_EN
    localparam int LAT = 1 + WC;
`else
    localparam int LAT = 1;
`endif

    logic          clock;
    logic          reset;
    logic          select;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          memory_type_data;
    logic          write;
    logic [DW-1:0] data_out;
    logic          data_ready;
    logic          addr_error;
    logic          busy;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] code_m [CD];
    logic [7:0] data_m [DD];
    logic [7:0] last_out;
    int         checks;
    int         passed;
    int         fails;

    spell_mem_regions #(
        .CODE_DEPTH (CD),
        .DATA_DEPTH (DD),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WAIT_CYCLES(WC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .select          (select),
        .addr            (addr),
        .data_in         (data_in),
        .memory_type_data(memory_type_data),
        .write           (write),
        .data_out        (data_out),
        .data_ready      (data_ready),
        .addr_error      (addr_error),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < CD; i++) code_m[i] = 8'h00;
        for (int i = 0; i < DD; i++) data_m[i] = 8'h00;
        last_out = 8'h00;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check(tag, n, CD);
    endtask

    // One handshake: predict, drive, await ready, compare, optionally hold then release.
    task automatic access(input bit wr, input bit reg_d, input logic [7:0] a,
                          input logic [7:0] din, input int hold, input bit keep,
                          input string tag);
        exp_t e;
        exp_t got;
        bit   inr;
        int   cyc;
        inr   = reg_d ? (a < DD) : (a < CD);
        e.err = !inr;
        if (wr) begin
            if (inr) begin
                if (reg_d) data_m[a[2:0]] = din;
                else       code_m[a[4:0]] = din;
            end
            e.data = last_out;
        end else begin
            e.data   = !inr ? 8'h00 : (reg_d ? data_m[a[2:0]] : code_m[a[4:0]]);
            last_out = e.data;
        end
        sb.push_back(e);

        @(negedge clock);
        select = 1'b1; write = wr; memory_type_data = reg_d; addr = a; data_in = din;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (data_ready !== 1'b1 && cyc < 50);
        check({tag, " latency"}, cyc, LAT);
        got = sb.pop_front();
        check({tag, " data_out"}, data_out, got.data);
        check({tag, " addr_error"}, addr_error, got.err);

        for (int i = 0; i < hold; i++) begin
            data_in = ~din;
            step();
            check({tag, " held ready"}, data_ready, 1);
            check({tag, " held addr_error"}, addr_error, got.err);
        end
        if (!keep) begin
            select = 1'b0; write = 1'b0;
            step();
            check({tag, " ready drop"}, data_ready, 0);
            check({tag, " error drop"}, addr_error, 0);
        end
    endtask

    initial begin
        checks = 0; passed = 0; fails = 0;
        reset = 1'b1; select = 1'b0; write = 1'b0; memory_type_data = REGION_CODE;
        addr = '0; data_in = '0;
        zero_model();

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", busy, 1);
        check("reset data_ready", data_ready, 0);
        check("reset data_out", data_out, 0);
        check("reset addr_error", addr_error, 0);

        reset = 1'b0;
        wait_clear("clear busy cycles");

        for (int i = 0; i < CD; i++) access(0, REGION_CODE, 8'(i), 8'h00, 0, 0, "init code");
        for (int i = 0; i < DD; i++) access(0, REGION_DATA, 8'(i), 8'h00, 0, 0, "init data");

        access(1, REGION_CODE, 8'd5, 8'hA5, 0, 0, "wr code5");
        access(0, REGION_CODE, 8'd5, 8'h00, 0, 0, "rd code5");

        access(1, REGION_DATA, 8'd7, 8'h77, 0, 0, "wr data7");
        access(1, REGION_DATA, 8'd8, 8'h55, 0, 0, "wr data8 oor");
        access(0, REGION_DATA, 8'd8, 8'h00, 0, 0, "rd data8 oor");
        access(0, REGION_DATA, 8'd255, 8'h00, 0, 0, "rd data255 oor");
        for (int i = 0; i < DD; i++) access(0, REGION_DATA, 8'(i), 8'h00, 0, 0, "rd data after oor");
        access(0, REGION_CODE, 8'd31, 8'h00, 0, 0, "rd code31");
        access(0, REGION_CODE, 8'd32, 8'h00, 0, 0, "rd code32 oor");

        access(1, REGION_CODE, 8'd6, 8'h42, 10, 0, "hold wr code6");
        access(0, REGION_CODE, 8'd6, 8'h00, 0, 0, "rd code6 once");

`ifdef SPELL_MEM_WAIT_EN
        @(negedge clock);
        select = 1'b1; write = 1'b1; memory_type_data = REGION_DATA; addr = 8'd2; data_in = 8'h3C;
        step();
        check("abort ready in wait a", data_ready, 0);
        step();
        check("abort ready in wait b", data_ready, 0);
        select = 1'b0; write = 1'b0;
        step();
        check("abort ready after drop", data_ready, 0);
        access(0, REGION_DATA, 8'd2, 8'h00, 0, 0, "rd data2 after abort");
`endif

        access(1, REGION_CODE, 8'd1, 8'h11, 0, 1, "wr code1 pre-reset");
        reset = 1'b1;
        step();
        check("reset in done ready", data_ready, 0);
        check("reset in done busy", busy, 1);
        check("reset in done data_out", data_out, 0);
        reset = 1'b0; select = 1'b0; write = 1'b0;
        zero_model();
        wait_clear("reclear busy cycles");
        access(0, REGION_CODE, 8'd1, 8'h00, 0, 0, "rd code1 after reclear");
        access(0, REGION_CODE, 8'd5, 8'h00, 0, 0, "rd code5 after reclear");
        access(0, REGION_DATA, 8'd7, 8'h00, 0, 0, "rd data7 after reclear");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
